clb_cfg_sequencer: RTL
======================

// Module: clb_cfg_sequencer
// PURPOSE
//   Sequences block-style configuration of NUM_SLICES F7/F8 mux slices. A serial
//   bitstream arrives over a valid/ready handshake. The block packs CFG_WIDTH bits
//   per slice and writes each slice's config_state with a one-cycle cen pulse.
//   It sits between the CLB bitstream source and the slices' cen/config_in pins.
// PARAMETERS
//   NUM_SLICES  4  slices configured in order, index 0 first
//   CFG_WIDTH   2  config bits per slice (= slice MUX_LEVEL)
// PORTS
//   cclk        in   1                  configuration clock; the only clock
//   rst_n       in   1                  asynchronous, active-low reset
//   start       in   1                  pulse: begin a full load sequence
//   abort       in   1                  pulse: drop the load and return to IDLE
//   cfg_bit     in   1                  serial config bit, LSB of each slice first
//   cfg_valid   in   1                  cfg_bit is valid
//   cfg_ready   out  1                  block accepts cfg_bit this cycle
//   cen         out  NUM_SLICES         one-hot write enable, one per slice
//   config_out  out  CFG_WIDTH          shared config_in bus to all slices
//   busy        out  1                  state is SHIFT or COMMIT
//   done        out  1                  all slices written; held until next start
//   err         out  1                  sticky protocol error; cleared by start from IDLE/DONE
// BEHAVIOUR
//   - Reset: all outputs 0, state IDLE, slice_idx 0, bit_cnt 0, shift_reg 0.
//   - Registers: every output is registered. cfg_ready is decoded from the state register.
//   - A bit transfer happens when cfg_valid & cfg_ready. cfg_bit is ignored at all other times.
//   - IDLE: cfg_ready 0.
//       start -> SHIFT; slice_idx 0, bit_cnt 0, done 0, err 0.
//   - SHIFT: cfg_ready 1.
//       On each transfer: shift_reg <= {cfg_bit, shift_reg[W-1:1]}, bit_cnt++.
//       Transfer with bit_cnt == CFG_WIDTH-1 -> COMMIT; bit_cnt wraps to 0.
//   - COMMIT (exactly 1 cycle): cfg_ready 0.
//       config_out <= shift_reg; cen[slice_idx] <= 1 for one cycle.
//       If slice_idx == NUM_SLICES-1 -> DONE. Otherwise slice_idx++ and -> SHIFT.
//   - Latency: the cen pulse is in the cycle after the COMMIT edge.
//       config_out is valid in that same cycle and holds until the next commit.
//   - DONE: done 1, cfg_ready 0.
//       start -> SHIFT (full reload, done cleared).
//   - Full load with continuous valid: NUM_SLICES*(CFG_WIDTH+1) cycles from SHIFT entry.
//   - start in SHIFT/COMMIT: ignored, err <= 1; the sequence continues.
//   - abort in any state: -> IDLE next cycle. No further cen; partial bits and bit_cnt discarded.
//       Slices already written keep their values. done <= 0. err is unchanged.
//   - start and abort in the same cycle: abort wins.
//   - abort during COMMIT: the registered cen of that commit still fires.
//       slice_idx and config_out are frozen.
//   - cen is never multi-hot and never high in two consecutive cycles.
//   - cfg_valid while cfg_ready 0: no error; the bit is simply not taken.
//   - rst_n low at any time: immediate return to reset values.
//       A cen pulse in progress is cut short.
// STRUCTURE
//   - Shared header clb_cfg_defs.vh: state encodings
//     (IDLE=2'd0, SHIFT=2'd1, COMMIT=2'd2, DONE=2'd3).
//   - Sub-module cfg_shift_accum: shift_reg + bit_cnt + "word complete" flag.
//     Parameter CFG_WIDTH, same async reset.
//   - Top-level holds the FSM, slice_idx counter, cen/config_out registers and the err/done flags.
//   - slice_idx width = $clog2(NUM_SLICES), minimum 1.
// TESTING (NUM_SLICES=4, CFG_WIDTH=2)
//   1. start, then stream 1,0,0,1,1,1,0,0 with valid held high.
//      -> cen sequence 0001,0010,0100,1000 with config_out 01,10,11,00.
//      -> done rises 12 cycles after SHIFT entry.
//   2. Random cfg_valid gaps (~50% duty).
//      -> same cen/config_out sequence.
//      -> cfg_ready is 0 in each COMMIT cycle, and no bit is lost.
//   3. start again mid-slice 1.
//      -> err=1; the load completes normally with done=1.
//      -> A following start clears err and done.
//   4. abort after 3 bits accepted.
//      -> IDLE; only cen[0] was pulsed.
//      -> A new start reloads from slice 0 with bit_cnt 0.
//   5. rst_n low for 1 cycle during the slice-2 COMMIT.
//      -> all outputs 0 asynchronously, state IDLE, no further cen.
//   6. start and abort together in IDLE.
//      -> remains IDLE, cfg_ready stays 0.

Source files
------------

// File: rtl/clb_cfg_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// clb_cfg_sequencer_pkg
//   Shared definitions for the CLB configuration sequencer:
//     - default slice count and per-slice config width
//     - FSM state encoding (IDLE=0, SHIFT=1, COMMIT=2, DONE=3)
//     - idx_width(): counter width for N items, never narrower than 1 bit
// -----------------------------------------------------------------------------
package clb_cfg_sequencer_pkg;

    localparam int NUM_SLICES_DEF = 4;
    localparam int CFG_WIDTH_DEF  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Width of an index over n items; a single item still needs one bit.
    function automatic int idx_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/clb_cfg_sequencer_shift_accum.sv
// -----------------------------------------------------------------------------
// cfg_shift_accum
//   Serial-to-parallel accumulator for one slice's configuration word.
//   Bits arrive LSB first and enter at the MSB, so after CFG_WIDTH shifts the
//   first bit has reached bit 0.
// Ports
//   cclk       in   configuration clock
//   rst_n      in   asynchronous active-low reset
//   clr        in   discard partial word (shift_reg and bit counter to 0)
//   shift_en   in   accept bit_in this cycle
//   bit_in     in   serial data bit
//   shift_reg  out  CFG_WIDTH-bit accumulated word (registered)
//   word_done  out  this shift completes a word (bit counter wraps to 0)
// -----------------------------------------------------------------------------
module cfg_shift_accum
    import clb_cfg_sequencer_pkg::*;
#(
    parameter int CFG_WIDTH = CFG_WIDTH_DEF
)
(
    input  logic                 cclk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 shift_en,
    input  logic                 bit_in,
    output logic [CFG_WIDTH-1:0] shift_reg,
    output logic                 word_done
);

    localparam int CNT_W = idx_width(CFG_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CFG_WIDTH - 1);

    logic [CFG_WIDTH-1:0] shift_reg_q;
    logic [CFG_WIDTH-1:0] shift_reg_d;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic [CNT_W-1:0]     bit_cnt_d;
    // One extra bit so the shift also works when CFG_WIDTH is 1.
    logic [CFG_WIDTH:0]   shifted_s;

    assign shifted_s = {bit_in, shift_reg_q};
    assign word_done = shift_en & (bit_cnt_q == LAST_BIT);
    assign shift_reg = shift_reg_q;

    // Next-state for the shift register and bit counter; clear beats shift.
    always_comb begin
        shift_reg_d = shift_reg_q;
        bit_cnt_d   = bit_cnt_q;
        if (clr) begin
            shift_reg_d = '0;
            bit_cnt_d   = '0;
        end else if (shift_en) begin
            shift_reg_d = shifted_s[CFG_WIDTH:1];
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end else begin
            shift_reg_d = shift_reg_q;
            bit_cnt_d   = bit_cnt_q;
        end
    end

    // Accumulator state registers.
    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg_q <= '0;
            bit_cnt_q   <= '0;
        end else begin
            shift_reg_q <= shift_reg_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/clb_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// clb_cfg_sequencer
//   Loads NUM_SLICES F7/F8 mux slices in order (slice 0 first) from a serial
//   bitstream. CFG_WIDTH bits are packed per slice, then that slice's cen bit
//   pulses for one cycle with the packed word on the shared config_out bus.
// Ports
//   cclk        in   configuration clock
//   rst_n       in   asynchronous active-low reset
//   start       in   begin a full load (from IDLE or DONE)
//   abort       in   drop the load, return to IDLE (wins over start)
//   cfg_bit     in   serial config bit, LSB of each slice first
//   cfg_valid   in   cfg_bit is valid
//   cfg_ready   out  bit accepted this cycle when valid (SHIFT state)
//   cen         out  one-hot per-slice write enable, single-cycle pulse
//   config_out  out  config word shared by all slices, held between commits
//   busy        out  SHIFT or COMMIT
//   done        out  all slices written; held until next start or abort
//   err         out  sticky: start seen while a load was running
// -----------------------------------------------------------------------------
module clb_cfg_sequencer
    import clb_cfg_sequencer_pkg::*;
#(
    parameter int NUM_SLICES = NUM_SLICES_DEF,
    parameter int CFG_WIDTH  = CFG_WIDTH_DEF
)
(
    input  logic                  cclk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  cfg_bit,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic [NUM_SLICES-1:0] cen,
    output logic [CFG_WIDTH-1:0]  config_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int IDX_W = idx_width(NUM_SLICES);
    localparam logic [IDX_W-1:0]      LAST_IDX     = IDX_W'(NUM_SLICES - 1);
    localparam logic [NUM_SLICES-1:0] ONE_HOT_BASE = NUM_SLICES'(1);

    state_e                state_q;
    state_e                state_d;
    logic [IDX_W-1:0]      slice_idx_q;
    logic [IDX_W-1:0]      slice_idx_d;
    logic [NUM_SLICES-1:0] cen_q;
    logic [NUM_SLICES-1:0] cen_d;
    logic [CFG_WIDTH-1:0]  config_out_q;
    logic [CFG_WIDTH-1:0]  config_out_d;
    logic                  done_q;
    logic                  done_d;
    logic                  err_q;
    logic                  err_d;

    logic                  xfer_s;
    logic                  acc_clr_s;
    logic [CFG_WIDTH-1:0]  acc_word_s;
    logic                  acc_word_done_s;

    // Ready and busy are plain decodes of the state register.
    assign cfg_ready  = (state_q == ST_SHIFT);
    assign busy       = (state_q == ST_SHIFT) || (state_q == ST_COMMIT);
    assign xfer_s     = cfg_valid & cfg_ready;
    assign cen        = cen_q;
    assign config_out = config_out_q;
    assign done       = done_q;
    assign err        = err_q;

    cfg_shift_accum #(
        .CFG_WIDTH (CFG_WIDTH)
    ) u_accum (
        .cclk      (cclk),
        .rst_n     (rst_n),
        .clr       (acc_clr_s),
        .shift_en  (xfer_s),
        .bit_in    (cfg_bit),
        .shift_reg (acc_word_s),
        .word_done (acc_word_done_s)
    );

    // FSM next-state plus slice index, cen, config_out, done and err updates.
    always_comb begin
        state_d      = state_q;
        slice_idx_d  = slice_idx_q;
        cen_d        = '0;
        config_out_d = config_out_q;
        done_d       = done_q;
        err_d        = err_q;
        acc_clr_s    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end else if (start) begin
                    state_d     = ST_SHIFT;
                    slice_idx_d = '0;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    acc_clr_s   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                if (abort) begin
                    // Partial word is thrown away; err keeps its value.
                    state_d   = ST_IDLE;
                    done_d    = 1'b0;
                    acc_clr_s = 1'b1;
                end else begin
                    if (start) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    if (acc_word_done_s) begin
                        state_d = ST_COMMIT;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end

            ST_COMMIT: begin
                // The write always happens, even if abort arrives now: the
                // slice receives the complete word it was committed with.
                cen_d        = ONE_HOT_BASE << slice_idx_q;
                config_out_d = acc_word_s;
                if (abort) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b0;
                    acc_clr_s = 1'b1;
                end else begin
                    if (start) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    if (slice_idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = ST_SHIFT;
                        slice_idx_d = slice_idx_q + IDX_W'(1);
                    end
                end
            end

            ST_DONE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end else if (start) begin
                    state_d     = ST_SHIFT;
                    slice_idx_d = '0;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    acc_clr_s   = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                acc_clr_s = 1'b1;
            end
        endcase
    end

    // State, index and output registers.
    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            slice_idx_q  <= '0;
            cen_q        <= '0;
            config_out_q <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            slice_idx_q  <= slice_idx_d;
            cen_q        <= cen_d;
            config_out_q <= config_out_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

endmodule
